// File: rtl/pong_anim_pkg.sv
// rtl/pong_anim_pkg.sv - coordinate type, colours and round-ball pattern for pong_anim
package pong_pkg;

    localparam int COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic {
        DIR_NEG = 1'b0,
        DIR_POS = 1'b1
    } dir_e;

    localparam logic [7:0] WALL_RGB = 8'b000_000_11;
    localparam logic [7:0] BAR_RGB  = 8'b000_111_00;
    localparam logic [7:0] BALL_RGB = 8'b111_000_00;
    localparam logic [7:0] BG_RGB   = 8'b000_000_00;

    // 8x8 round ball; column 0 is the MSB of each row
    function automatic logic ball_rom_bit(input logic [2:0] row, input logic [2:0] col);
        logic [7:0] bits;
        case (row)
            3'd0, 3'd7: bits = 8'h3C;
            3'd1, 3'd6: bits = 8'h7E;
            default:    bits = 8'hFF;
        endcase
        return bits[~col];
    endfunction

endpackage

// File: rtl/pong_anim_if.sv
// rtl/pong_anim_if.sv - video path between timing generator, pong_anim and the pins
interface pong_anim_if;
    import pong_pkg::*;

    coord_t     x;
    coord_t     y;
    logic       blank;
    logic       HS_IN;
    logic       VS_IN;
    logic       HS;
    logic       VS;
    logic [7:0] RGB;

    modport master (output x, y, blank, HS_IN, VS_IN, input HS, VS, RGB);
    modport slave  (input x, y, blank, HS_IN, VS_IN, output HS, VS, RGB);

endinterface

// File: rtl/pong_anim_ball_motion.sv
// rtl/pong_anim_ball_motion.sv - ball position, direction and saturating miss count, stepped on tick
module pong_ball_motion
    import pong_pkg::*;
#(
    parameter int MAX_X      = 640,
    parameter int MAX_Y      = 480,
    parameter int WALL_X_R   = 35,
    parameter int BAR_X_L    = 580,
    parameter int BAR_X_R    = 583,
    parameter int BAR_Y_SIZE = 72,
    parameter int BALL_SIZE  = 8,
    parameter int BALL_V     = 2,
    parameter int MISS_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  coord_t            bar_y_t,
    output coord_t            ball_x_l,
    output coord_t            ball_y_t,
    output logic [MISS_W-1:0] miss_cnt
);

    localparam coord_t X_RST      = coord_t'(MAX_X / 2 - BALL_SIZE / 2);
    localparam coord_t Y_RST      = coord_t'(MAX_Y / 2 - BALL_SIZE / 2);
    localparam coord_t BALL_M1    = coord_t'(BALL_SIZE - 1);
    localparam coord_t STEP       = coord_t'(BALL_V);
    localparam coord_t MISS_X     = coord_t'(MAX_X - 1 - BALL_V);
    localparam coord_t WALL_HIT   = coord_t'(WALL_X_R + BALL_V);
    localparam coord_t BAR_HIT_L  = coord_t'(BAR_X_L - BALL_V);
    localparam coord_t BAR_HIT_R  = coord_t'(BAR_X_R);
    localparam coord_t BAR_M1     = coord_t'(BAR_Y_SIZE - 1);
    localparam coord_t BOT_BOUNCE = coord_t'(MAX_Y - 1 - BALL_V);

    coord_t            x_q, x_d, y_q, y_d;
    coord_t            ball_x_r, ball_y_b;
    dir_e              dx_q, dx_d, dy_q, dy_d, dx_n, dy_n;
    logic [MISS_W-1:0] miss_q, miss_d;

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        dx_n     = dx_q;
        dy_n     = dy_q;
        miss_d   = miss_q;
        ball_x_r = x_q + BALL_M1;
        ball_y_b = y_q + BALL_M1;
        if (tick) begin
            if (ball_x_r >= MISS_X) begin
                // a miss overrides every bounce rule and skips the step
                x_d  = X_RST;
                y_d  = Y_RST;
                dx_d = DIR_POS;
                if (miss_q != {MISS_W{1'b1}}) begin
                    miss_d = miss_q + MISS_W'(1);
                end
            end else begin
                if (x_q <= WALL_HIT) begin
                    dx_n = DIR_POS;
                end else if ((ball_x_r >= BAR_HIT_L) && (ball_x_r <= BAR_HIT_R) &&
                             (ball_y_b >= bar_y_t) && (y_q <= bar_y_t + BAR_M1)) begin
                    dx_n = DIR_NEG;
                end
                if (y_q < STEP) begin
                    dy_n = DIR_POS;
                end else if (ball_y_b > BOT_BOUNCE) begin
                    dy_n = DIR_NEG;
                end
                dx_d = dx_n;
                dy_d = dy_n;
                x_d  = (dx_n == DIR_POS) ? x_q + STEP : x_q - STEP;
                y_d  = (dy_n == DIR_POS) ? y_q + STEP : y_q - STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q    <= X_RST;
            y_q    <= Y_RST;
            dx_q   <= DIR_POS;
            dy_q   <= DIR_POS;
            miss_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            dx_q   <= dx_d;
            dy_q   <= dy_d;
            miss_q <= miss_d;
        end
    end

    assign ball_x_l = x_q;
    assign ball_y_t = y_q;
    assign miss_cnt = miss_q;

endmodule

// File: rtl/pong_anim.sv
// rtl/pong_anim.sv - animated pong renderer: paddle, pixel mux, delayed syncs; ROUND_BALL_EN selects the round ball
module pong_anim
    import pong_pkg::*;
#(
    parameter int MAX_X      = 640,
    parameter int MAX_Y      = 480,
    parameter int WALL_X_L   = 32,
    parameter int WALL_X_R   = 35,
    parameter int BAR_X_L    = 580,
    parameter int BAR_X_R    = 583,
    parameter int BAR_Y_SIZE = 72,
    parameter int BAR_V      = 4,
    parameter int BALL_SIZE  = 8,
    parameter int BALL_V     = 2,
    parameter int MISS_W     = 4
) (
    input  logic              CLK,
    input  logic              RST,
    pong_anim_if.slave        vid,
    input  logic              BTN_UP,
    input  logic              BTN_DN,
    output logic [MISS_W-1:0] MISS_CNT,
    output logic              FRAME_TICK
);

    localparam coord_t TICK_Y   = coord_t'(MAX_Y);
    localparam coord_t BOT_LIM  = coord_t'(MAX_Y - 1);
    localparam coord_t BAR_RST  = coord_t'(MAX_Y / 2 - BAR_Y_SIZE / 2);
    localparam coord_t BAR_BOT  = coord_t'(MAX_Y - BAR_Y_SIZE);
    localparam coord_t BAR_M1   = coord_t'(BAR_Y_SIZE - 1);
    localparam coord_t BAR_STEP = coord_t'(BAR_V);
    localparam coord_t BAR_L    = coord_t'(BAR_X_L);
    localparam coord_t BAR_R    = coord_t'(BAR_X_R);
    localparam coord_t WALL_L   = coord_t'(WALL_X_L);
    localparam coord_t WALL_R   = coord_t'(WALL_X_R);
    localparam coord_t BALL_M1  = coord_t'(BALL_SIZE - 1);

    logic       tick;
    coord_t     bar_y_t_q, bar_y_t_d;
    coord_t     ball_x_l, ball_y_t;
    logic       frame_tick_q, frame_tick_d;
    logic       hs_q, hs_d, vs_q, vs_d;
    logic [7:0] rgb_q, rgb_d;
    logic       wall_on, bar_on, ball_sq, ball_on;

    assign tick = (vid.y == TICK_Y) && (vid.x == '0);

    pong_ball_motion #(
        .MAX_X      (MAX_X),
        .MAX_Y      (MAX_Y),
        .WALL_X_R   (WALL_X_R),
        .BAR_X_L    (BAR_X_L),
        .BAR_X_R    (BAR_X_R),
        .BAR_Y_SIZE (BAR_Y_SIZE),
        .BALL_SIZE  (BALL_SIZE),
        .BALL_V     (BALL_V),
        .MISS_W     (MISS_W)
    ) u_ball (
        .clk      (CLK),
        .rst      (RST),
        .tick     (tick),
        .bar_y_t  (bar_y_t_q),
        .ball_x_l (ball_x_l),
        .ball_y_t (ball_y_t),
        .miss_cnt (MISS_CNT)
    );

    always_comb begin
        bar_y_t_d = bar_y_t_q;
        if (tick) begin
            if (BTN_UP && !BTN_DN) begin
                bar_y_t_d = (bar_y_t_q >= BAR_STEP) ? bar_y_t_q - BAR_STEP : '0;
            end else if (BTN_DN && !BTN_UP) begin
                bar_y_t_d = (bar_y_t_q + BAR_M1 + BAR_STEP <= BOT_LIM) ? bar_y_t_q + BAR_STEP : BAR_BOT;
            end
        end
    end

    // rendering uses the registered positions, i.e. those from the last tick
    always_comb begin
        wall_on = (vid.x >= WALL_L) && (vid.x <= WALL_R);
        bar_on  = (vid.x >= BAR_L) && (vid.x <= BAR_R) &&
                  (vid.y >= bar_y_t_q) && (vid.y <= bar_y_t_q + BAR_M1);
        ball_sq = (vid.x >= ball_x_l) && (vid.x <= ball_x_l + BALL_M1) &&
                  (vid.y >= ball_y_t) && (vid.y <= ball_y_t + BALL_M1);
`ifdef ROUND_BALL_EN
        ball_on = ball_sq && ball_rom_bit(vid.y[2:0] - ball_y_t[2:0], vid.x[2:0] - ball_x_l[2:0]);
`else
        ball_on = ball_sq;
`endif
        if (vid.blank)    rgb_d = BG_RGB;
        else if (wall_on) rgb_d = WALL_RGB;
        else if (bar_on)  rgb_d = BAR_RGB;
        else if (ball_on) rgb_d = BALL_RGB;
        else              rgb_d = BG_RGB;
        hs_d         = vid.HS_IN;
        vs_d         = vid.VS_IN;
        frame_tick_d = tick;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bar_y_t_q    <= BAR_RST;
            rgb_q        <= BG_RGB;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            bar_y_t_q    <= bar_y_t_d;
            rgb_q        <= rgb_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign vid.RGB    = rgb_q;
    assign vid.HS     = hs_q;
    assign vid.VS     = vs_q;
    assign FRAME_TICK = frame_tick_q;

endmodule
